mesi_isc_breq_arb: RTL and testbench

MESI_ISC_BREQ_ARB -- requirements
Module: mesi_isc_breq_arb

---
 rtl/mesi_isc_breq_arb.sv | 120 ++++++++++++
 tb/tb_mesi_isc_breq_arb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_isc_breq_arb.sv
// Broadcast-request arbiter: picks one CPU request queue head round-robin,
// pops it and pushes it into the broadcast FIFO, then idles one gap cycle.
module mesi_isc_breq_arb #(
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    breq_valid_array_i,
  input  logic [4*BROAD_TYPE_WIDTH-1:0] breq_type_array_i,
  input  logic [4*BROAD_ID_WIDTH-1:0]   breq_id_array_i,
  input  logic [4*ADDR_WIDTH-1:0]       breq_addr_array_i,
  input  logic                          broad_fifo_full_i,
  output logic [3:0]                    breq_rd_array_o,
  output logic                          broad_fifo_wr_o,
  output logic [BROAD_TYPE_WIDTH-1:0]   broad_type_o,
  output logic [1:0]                    broad_cpu_id_o,
  output logic [BROAD_ID_WIDTH-1:0]     broad_id_o,
  output logic [ADDR_WIDTH-1:0]         broad_addr_o,
  output logic [1:0]                    dbg_state_o,
  output logic [1:0]                    dbg_rr_ptr_o
);

  localparam logic [BROAD_TYPE_WIDTH-1:0] MESI_ISC_BREQ_TYPE_NOP = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [1:0]                    r_rr_ptr;
  logic [3:0]                    r_rd;
  logic                          r_wr;
  logic [BROAD_TYPE_WIDTH-1:0]   r_type;
  logic [1:0]                    r_cpu_id;
  logic [BROAD_ID_WIDTH-1:0]     r_id;
  logic [ADDR_WIDTH-1:0]         r_addr;

  logic [7:0]                    w_valid_dbl;
  logic [3:0]                    w_valid_rot;
  logic [1:0]                    w_offset;
  logic [1:0]                    w_winner;
  logic [3:0]                    w_onehot;
  logic                          w_take;
  logic [BROAD_TYPE_WIDTH-1:0]   w_type;
  logic [BROAD_ID_WIDTH-1:0]     w_id;
  logic [ADDR_WIDTH-1:0]         w_addr;

  // Rotate the valid vector so bit 0 is the CPU at rr_ptr; the lowest set
  // bit of the rotated vector is then the round-robin winner.
  assign w_valid_dbl = {breq_valid_array_i, breq_valid_array_i};
  assign w_valid_rot = w_valid_dbl[r_rr_ptr +: 4];

  always_comb begin
    w_offset = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_valid_rot[k]) w_offset = 2'(k);
    end
  end

  assign w_winner = r_rr_ptr + w_offset;
  assign w_onehot = 4'b0001 << w_winner;
  assign w_type   = breq_type_array_i[w_winner*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
  assign w_id     = breq_id_array_i[w_winner*BROAD_ID_WIDTH +: BROAD_ID_WIDTH];
  assign w_addr   = breq_addr_array_i[w_winner*ADDR_WIDTH +: ADDR_WIDTH];

  // The FIFO full flag only matters at decision time; once committed, the
  // push completes because nothing else writes the FIFO.
  assign w_take = (r_state == ST_IDLE) && (|breq_valid_array_i) && !broad_fifo_full_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_take) w_state_nxt = ST_PUSH;
      ST_PUSH: w_state_nxt = ST_GAP;
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= 2'd0;
      r_rd     <= 4'b0000;
      r_wr     <= 1'b0;
      r_type   <= '0;
      r_cpu_id <= 2'd0;
      r_id     <= '0;
      r_addr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rd    <= 4'b0000;
      r_wr    <= 1'b0;
      if (w_take) begin
        r_rr_ptr <= w_winner + 2'd1;
        r_rd     <= w_onehot;
        r_wr     <= (w_type != MESI_ISC_BREQ_TYPE_NOP);
        r_type   <= w_type;
        r_cpu_id <= w_winner;
        r_id     <= w_id;
        r_addr   <= w_addr;
      end
    end
  end

  assign breq_rd_array_o = r_rd;
  assign broad_fifo_wr_o = r_wr;
  assign broad_type_o    = r_type;
  assign broad_cpu_id_o  = r_cpu_id;
  assign broad_id_o      = r_id;
  assign broad_addr_o    = r_addr;
  assign dbg_state_o     = r_state;
  assign dbg_rr_ptr_o    = r_rr_ptr;

endmodule

// File: tb/tb_mesi_isc_breq_arb.sv
// Directed bench for mesi_isc_breq_arb: inputs driven on the falling edge,
// outputs checked on the following falling edge.
module tb_mesi_isc_breq_arb;

  localparam int TW = 2;
  localparam int IW = 5;
  localparam int AW = 32;

  localparam logic [TW-1:0] T_NOP = 2'd0;
  localparam logic [TW-1:0] T_WR  = 2'd1;
  localparam logic [TW-1:0] T_RD  = 2'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PUSH = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic              clk;
  logic              rst;
  logic [3:0]        valid;
  logic [4*TW-1:0]   types;
  logic [4*IW-1:0]   ids;
  logic [4*AW-1:0]   addrs;
  logic              full;
  logic [3:0]        rd;
  logic              wr;
  logic [TW-1:0]     b_type;
  logic [1:0]        b_cpu;
  logic [IW-1:0]     b_id;
  logic [AW-1:0]     b_addr;
  logic [1:0]        dbg_state;
  logic [1:0]        dbg_rr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  mesi_isc_breq_arb #(
    .BROAD_TYPE_WIDTH(TW),
    .BROAD_ID_WIDTH  (IW),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .breq_valid_array_i(valid),
    .breq_type_array_i (types),
    .breq_id_array_i   (ids),
    .breq_addr_array_i (addrs),
    .broad_fifo_full_i (full),
    .breq_rd_array_o   (rd),
    .broad_fifo_wr_o   (wr),
    .broad_type_o      (b_type),
    .broad_cpu_id_o    (b_cpu),
    .broad_id_o        (b_id),
    .broad_addr_o      (b_addr),
    .dbg_state_o       (dbg_state),
    .dbg_rr_ptr_o      (dbg_rr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input int n, input logic [TW-1:0] t,
                         input logic [IW-1:0] id, input logic [AW-1:0] a);
    types[n*TW +: TW] = t;
    ids[n*IW +: IW]   = id;
    addrs[n*AW +: AW] = a;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd"}, 64'(rd), 64'h0);
    chk({tag, "_wr"}, 64'(wr), 64'h0);
  endtask

  initial begin
    logic [1:0] e;
    logic [3:0] e_rd;
    rst = 1'b0; valid = 4'b0; types = '0; ids = '0; addrs = '0; full = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_rd", 64'(rd), 64'h0);
    chk("rst_wr", 64'(wr), 64'h0);
    chk("rst_type", 64'(b_type), 64'h0);
    chk("rst_cpu", 64'(b_cpu), 64'h0);
    chk("rst_id", 64'(b_id), 64'h0);
    chk("rst_addr", 64'(b_addr), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
    chk("rst_rr", 64'(dbg_rr), 64'h0);
    rst = 1'b1;

    // Single request from CPU2
    set_cpu(2, T_RD, 5'h0A, 32'h1000);
    valid = 4'b0100;
    tick();
    chk("single_rd", 64'(rd), 64'h4);
    chk("single_wr", 64'(wr), 64'h1);
    chk("single_cpu", 64'(b_cpu), 64'h2);
    chk("single_id", 64'(b_id), 64'h0A);
    chk("single_addr", 64'(b_addr), 64'h1000);
    chk("single_type", 64'(b_type), 64'(T_RD));
    chk("single_rr", 64'(dbg_rr), 64'h3);
    chk("single_state", 64'(dbg_state), 64'(S_PUSH));
    valid = 4'b0000;
    set_cpu(2, T_WR, 5'h15, 32'hDEAD_BEEF);
    tick();
    chk_quiet("gap");
    chk("gap_state", 64'(dbg_state), 64'(S_GAP));
    chk("hold_addr", 64'(b_addr), 64'h1000);
    chk("hold_id", 64'(b_id), 64'h0A);
    tick();
    chk("idle_state", 64'(dbg_state), 64'(S_IDLE));
    chk_quiet("idle");

    // Wrap: rr_ptr=3, CPU3 before CPU0
    set_cpu(0, T_WR, 5'h01, 32'h2000);
    set_cpu(3, T_RD, 5'h1F, 32'h3000);
    valid = 4'b1001;
    tick();
    chk("wrap3_rd", 64'(rd), 64'h8);
    chk("wrap3_cpu", 64'(b_cpu), 64'h3);
    chk("wrap3_addr", 64'(b_addr), 64'h3000);
    chk("wrap3_rr", 64'(dbg_rr), 64'h0);
    valid = 4'b0001;
    tick(); chk_quiet("wrap_gap");
    tick(); chk_quiet("wrap_idle");
    tick();
    chk("wrap0_rd", 64'(rd), 64'h1);
    chk("wrap0_wr", 64'(wr), 64'h1);
    chk("wrap0_cpu", 64'(b_cpu), 64'h0);
    chk("wrap0_type", 64'(b_type), 64'(T_WR));
    chk("wrap0_addr", 64'(b_addr), 64'h2000);
    chk("wrap0_rr", 64'(dbg_rr), 64'h1);
    valid = 4'b0000;
    repeat (2) tick();

    // NOP head on CPU1 is popped without a push
    set_cpu(1, T_NOP, 5'h03, 32'h4000);
    set_cpu(2, T_RD, 5'h04, 32'h5000);
    set_cpu(3, T_RD, 5'h05, 32'h6000);
    valid = 4'b1110;
    tick();
    chk("nop_rd", 64'(rd), 64'h2);
    chk("nop_wr", 64'(wr), 64'h0);
    chk("nop_cpu", 64'(b_cpu), 64'h1);
    chk("nop_rr", 64'(dbg_rr), 64'h2);
    valid = 4'b1100;
    tick(); chk_quiet("nop_gap");
    tick();
    tick();
    chk("after_nop_rd", 64'(rd), 64'h4);
    chk("after_nop_wr", 64'(wr), 64'h1);
    chk("after_nop_addr", 64'(b_addr), 64'h5000);
    chk("after_nop_rr", 64'(dbg_rr), 64'h3);
    valid = 4'b0000;
    repeat (2) tick();

    // Full stall, then release
    set_cpu(0, T_RD, 5'h06, 32'h7000);
    valid = 4'b0001;
    full  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_quiet("stall");
      chk("stall_state", 64'(dbg_state), 64'(S_IDLE));
    end
    full = 1'b0;
    tick();
    chk("unstall_rd", 64'(rd), 64'h1);
    chk("unstall_wr", 64'(wr), 64'h1);
    chk("unstall_addr", 64'(b_addr), 64'h7000);
    full  = 1'b1;
    valid = 4'b0000;
    tick();
    chk("late_full_state", 64'(dbg_state), 64'(S_GAP));
    chk("late_full_addr", 64'(b_addr), 64'h7000);
    tick();
    full = 1'b0;

    // Reset asserted during PUSH
    set_cpu(1, T_RD, 5'h07, 32'h8000);
    valid = 4'b0010;
    tick();
    chk("pre_rst_rd", 64'(rd), 64'h2);
    chk("pre_rst_wr", 64'(wr), 64'h1);
    chk("pre_rst_rr", 64'(dbg_rr), 64'h2);
    rst = 1'b0;
    #1;
    chk("async_rd", 64'(rd), 64'h0);
    chk("async_wr", 64'(wr), 64'h0);
    chk("async_addr", 64'(b_addr), 64'h0);
    chk("async_cpu", 64'(b_cpu), 64'h0);
    chk("async_state", 64'(dbg_state), 64'(S_IDLE));
    chk("async_rr", 64'(dbg_rr), 64'h0);
    valid = 4'b0000;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("post_rst");
    end
    chk("post_rst_rr", 64'(dbg_rr), 64'h0);

    // Round-robin with all four queues busy
    for (int n = 0; n < 4; n++) begin
      set_cpu(n, T_RD, IW'(16 + n), AW'(32'hA000 + n));
      exp_q.push_back(2'(n));
    end
    valid = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("rr_wr_%0d", i), 64'(wr), 64'((i % 3) == 0));
      if (wr === 1'b1 && exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        e_rd = 4'b0001 << e;
        chk($sformatf("rr_cpu_%0d", i), 64'(b_cpu), 64'(e));
        chk($sformatf("rr_rd_%0d", i), 64'(rd), 64'(e_rd));
        chk($sformatf("rr_id_%0d", i), 64'(b_id), 64'(16 + int'(e)));
      end
    end
    chk("rr_all_granted", 64'(exp_q.size()), 64'h0);
    chk("rr_final_ptr", 64'(dbg_rr), 64'h0);
    valid = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
